// File: rtl/udma_l2_tcdm_mux.sv
// Merges the uDMA read-only and write-only TCDM masters onto one L2 bank port.
// Round-robin arbitration with a stall lock; an owner FIFO steers responses back in order.
module udma_l2_tcdm_mux #(
    parameter int ADDR_WIDTH      = 32,
    parameter int DATA_WIDTH      = 32,
    parameter int MAX_OUTSTANDING = 4
) (
    input  logic                    sys_clk_i,
    input  logic                    sys_resetn_i,

    input  logic                    ro_req_i,
    input  logic                    ro_wen_i,
    input  logic [ADDR_WIDTH-1:0]   ro_addr_i,
    input  logic [DATA_WIDTH/8-1:0] ro_be_i,
    input  logic [DATA_WIDTH-1:0]   ro_wdata_i,
    output logic                    ro_gnt_o,
    output logic                    ro_rvalid_o,
    output logic [DATA_WIDTH-1:0]   ro_rdata_o,

    input  logic                    wo_req_i,
    input  logic                    wo_wen_i,
    input  logic [ADDR_WIDTH-1:0]   wo_addr_i,
    input  logic [DATA_WIDTH/8-1:0] wo_be_i,
    input  logic [DATA_WIDTH-1:0]   wo_wdata_i,
    output logic                    wo_gnt_o,
    output logic                    wo_rvalid_o,
    output logic [DATA_WIDTH-1:0]   wo_rdata_o,

    output logic                    mem_req_o,
    output logic                    mem_wen_o,
    output logic [ADDR_WIDTH-1:0]   mem_addr_o,
    output logic [DATA_WIDTH/8-1:0] mem_be_o,
    output logic [DATA_WIDTH-1:0]   mem_wdata_o,
    input  logic                    mem_gnt_i,
    input  logic                    mem_rvalid_i,
    input  logic [DATA_WIDTH-1:0]   mem_rdata_i,

    output logic                    err_o
);

    localparam int PW = (MAX_OUTSTANDING > 1) ? $clog2(MAX_OUTSTANDING) : 1;
    localparam int CW = $clog2(MAX_OUTSTANDING) + 1;
    localparam logic [CW-1:0] FULL_CNT = CW'(MAX_OUTSTANDING);
    localparam logic [PW-1:0] LAST_PTR = PW'(MAX_OUTSTANDING - 1);

    logic                       prio;
    logic                       lock;
    logic                       lock_sel;
    logic                       sel;
    logic [MAX_OUTSTANDING-1:0] owner_q;
    logic [PW-1:0]              wptr;
    logic [PW-1:0]              rptr;
    logic [CW-1:0]              count;
    logic                       full;
    logic                       empty;
    logic                       transfer;
    logic                       pop;
    logic                       head;

    function automatic logic [PW-1:0] ptr_next(input logic [PW-1:0] p);
        return (p == LAST_PTR) ? '0 : p + 1'b1;
    endfunction

    // sel: 0 = ro, 1 = wo
    always_comb begin
        sel = 1'b0;
        if (lock)
            sel = lock_sel;
        else if (ro_req_i && wo_req_i)
            sel = prio;
        else
            sel = wo_req_i;
    end

    assign full     = (count == FULL_CNT);
    assign empty    = (count == '0);
    assign head     = owner_q[rptr];

    assign mem_req_o   = ~full & (sel ? wo_req_i : ro_req_i);
    assign mem_wen_o   = sel ? wo_wen_i   : ro_wen_i;
    assign mem_addr_o  = sel ? wo_addr_i  : ro_addr_i;
    assign mem_be_o    = sel ? wo_be_i    : ro_be_i;
    assign mem_wdata_o = sel ? wo_wdata_i : ro_wdata_i;

    assign transfer = mem_req_o & mem_gnt_i;
    assign pop      = mem_rvalid_i & ~empty;

    assign ro_gnt_o    = transfer & ~sel;
    assign wo_gnt_o    = transfer & sel;
    assign ro_rvalid_o = pop & ~head;
    assign wo_rvalid_o = pop & head;
    assign ro_rdata_o  = mem_rdata_i;
    assign wo_rdata_o  = mem_rdata_i;

    always_ff @(posedge sys_clk_i or negedge sys_resetn_i) begin
        if (!sys_resetn_i) begin
            prio     <= 1'b0;
            lock     <= 1'b0;
            lock_sel <= 1'b0;
            owner_q  <= '0;
            wptr     <= '0;
            rptr     <= '0;
            count    <= '0;
            err_o    <= 1'b0;
        end else begin
            // A stalled request pins the selection; a dropped request releases it.
            lock     <= mem_req_o & ~mem_gnt_i;
            lock_sel <= sel;
            if (transfer) begin
                owner_q[wptr] <= sel;
                wptr          <= ptr_next(wptr);
                if (ro_req_i && wo_req_i)
                    prio <= ~prio;
            end
            if (pop)
                rptr <= ptr_next(rptr);
            case ({transfer, pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
            if (mem_rvalid_i && empty)
                err_o <= 1'b1;
        end
    end

endmodule
